pc_redirect: RTL and testbench
==============================

# pc_redirect

- Fetch-side counterpart of the ID-stage branch comparator.
- Owns the fetch PC register and consumes the resolved branch decision (`zero_B`) plus the jump/jr decode from ID.
- Computes targets and redirects fetch, honouring the MIPS one-instruction delay slot.
- Buffers the redirect when instruction memory has not yet accepted the delay-slot fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall; IF and ID hold, decode inputs ignored.
- br_valid  in  1  ID holds a control-transfer instruction this cycle.
- br_type  in  2  00 none, 01 conditional branch, 10 j/jal, 11 jr/jalr.
- zero_B  in  1  comparator result; 1 = condition true.
- id_pc  in  32  PC of the ID-stage instruction.
- imm16  in  16  branch offset field.
- instr_index  in  26  jump index field.
- jr_target  in  32  forwarded rs value.
- fetch_ready  in  1  imem accepts `pc_f` this cycle.
- pc_f  out  32  registered current fetch address.
- link_addr  out  32  combinational `id_pc + 8`.
- redirect_pending  out  1  a taken redirect waits for fetch acceptance.
- misalign  out  1  one-cycle pulse: `jr_target[1:0] != 0` on an accepted jr.

## Operation
Decision accepted = `br_valid & ~stall & ~redirect_pending`.
- Taken when `br_type==01 & zero_B`, or `br_type` is 10 or 11.

Targets (all 32-bit, wrap modulo 2^32):
- Branch: `id_pc + 4 + (sign_ext(imm16) << 2)`.
- Jump: `{(id_pc+4)[31:28], instr_index, 2'b00}`.
- jr: `{jr_target[31:2], 2'b00}`; misalign pulses if the low bits are non-zero.

State machine: RUN, PEND.
- **RUN**, fetch advance (`fetch_ready & ~stall`):
  - Taken decision: `pc_f <= target`.
  - Otherwise: `pc_f <= pc_f + 4`.
- **RUN**, taken decision while `fetch_ready==0` (delay slot not yet fetched):
  - Latch target into the internal `tgt_q`.
  - `pc_f` holds; go to PEND.
- **PEND**, `fetch_ready & ~stall`: `pc_f <= tgt_q`, return to RUN.
- **PEND**, otherwise: hold.
- **PEND**, `br_valid`: ignored (ID holds a bubble by construction); bench flags it as a protocol error.
- Not-taken decision: no state change; sequential fetch continues.
- `stall==1`: `pc_f`, state and `tgt_q` hold regardless of `fetch_ready`; `br_valid` is not sampled.
- Reset asserted mid-PEND: pending target discarded; `pc_f = RESET_PC`.

## Timing
- Reset values: `pc_f = RESET_PC`, `redirect_pending = 0`, `misalign = 0`, state RUN, `tgt_q = 0`.
- Taken decision at edge k with `fetch_ready=1`: `pc_f = target` after edge k (zero bubble beyond the delay slot).
- Taken decision with `fetch_ready=0`:
  - `redirect_pending = 1` from edge k.
  - `pc_f = target` after the first subsequent edge where `fetch_ready & ~stall`.
  - `redirect_pending = 0` at that same edge.
- `misalign` is registered: high for exactly the cycle after the accepting edge.
- `link_addr` has no latency.

## Configuration
- `PC_REDIRECT_STAT_EN` defined:
  - Adds outputs `br_total[15:0]` (accepted decisions with `br_type != 00`) and `br_taken[15:0]` (taken ones).
  - Both counters saturate at 16'hFFFF, reset to 0 and hold during stall.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset mid-run: assert `reset_n=0` while `pc_f = 0x3010` -> `pc_f = 0x3000` immediately; RUN; no pending.
- BEQ taken: `id_pc=0x3004`, `imm16=0x0003`, `zero_B=1`, `fetch_ready=1` -> `pc_f` goes 0x3008 -> 0x3014. Not-taken (`zero_B=0`) -> 0x300C.
- Negative offset with wrap:
  - `id_pc=0x0000_0000`, `imm16=0xFFFE` -> target 0xFFFF_FFFC.
  - `j` with `id_pc=0x3FFF_FFFC`, `instr_index=0x0000004` -> target 0x4000_0010.
- Delayed acceptance:
  - `fetch_ready=0` for 3 cycles after taken jr (`jr_target=0x3100`) -> `redirect_pending=1` and `pc_f` holds the delay-slot address.
  - First `fetch_ready=1` edge -> `pc_f = 0x3100`, pending clears.
- Stall precedence: `stall=1` with `br_valid=1`, taken, `fetch_ready=1` -> `pc_f` unchanged. Release stall -> redirect on the next edge.
- Misaligned jr: `jr_target=0x3102` -> `pc_f = 0x3100`, `misalign` high one cycle. With `PC_REDIRECT_STAT_EN`: `br_total` and `br_taken` each increment by 1.

Source files
------------

// File: rtl/pc_redirect.sv
// -----------------------------------------------------------------------------
// pc_redirect
// Fetch-side PC owner. Takes the ID-stage branch/jump decision, computes the
// control-transfer target and redirects fetch. The instruction after a branch
// (the MIPS delay slot) is always fetched. If imem has not yet accepted that
// delay-slot fetch, the target is buffered until it does.
//
// Optional build macro:
//   PC_REDIRECT_STAT_EN - adds saturating decision counters br_total/br_taken.
//
// Ports:
//   clk              in   sole clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   stall            in   hazard stall; IF/ID hold, decode inputs ignored
//   br_valid         in   ID holds a control-transfer instruction
//   br_type [1:0]    in   00 none, 01 cond branch, 10 j/jal, 11 jr/jalr
//   zero_B           in   comparator result, 1 = condition true
//   id_pc [31:0]     in   PC of the ID-stage instruction
//   imm16 [15:0]     in   branch offset field
//   instr_index[25:0]in   jump index field
//   jr_target [31:0] in   forwarded rs value
//   fetch_ready      in   imem accepts pc_f this cycle
//   pc_f [31:0]      out  registered fetch address
//   link_addr [31:0] out  id_pc + 8 (combinational)
//   redirect_pending out  a taken redirect waits for fetch acceptance
//   misalign         out  one-cycle pulse after an accepted jr with low bits set
//   br_total [15:0]  out  (PC_REDIRECT_STAT_EN) accepted decisions, type != 00
//   br_taken [15:0]  out  (PC_REDIRECT_STAT_EN) accepted taken decisions
// -----------------------------------------------------------------------------
module pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [1:0]  br_type,
    input  logic        zero_B,
    input  logic [31:0] id_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    input  logic        fetch_ready,
    output logic [31:0] pc_f,
    output logic [31:0] link_addr,
    output logic        redirect_pending,
    output logic        misalign
`ifdef PC_REDIRECT_STAT_EN
    ,
    output logic [15:0] br_total,
    output logic [15:0] br_taken
`endif
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_tgt_q;
    logic [31:0] w_tgt_nxt;
    logic        r_misalign;
    logic        w_misalign_nxt;

    logic        w_accept;
    logic        w_taken;
    logic        w_advance;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_jr_tgt;
    logic [31:0] w_target;

    // While a redirect is pending ID holds a bubble, so br_valid is not sampled.
    assign w_accept   = br_valid & ~stall & (r_state == ST_RUN);
    assign w_advance  = fetch_ready & ~stall;

    // Target arithmetic, all modulo 2^32.
    assign w_pc_plus4 = id_pc + 32'd4;
    assign w_br_off   = {{14{imm16[15]}}, imm16, 2'b00};
    assign w_br_tgt   = w_pc_plus4 + w_br_off;
    assign w_j_tgt    = {w_pc_plus4[31:28], instr_index, 2'b00};
    assign w_jr_tgt   = {jr_target[31:2], 2'b00};

    assign link_addr  = id_pc + 32'd8;

    // Taken decision and target select from the decoded branch type.
    always_comb begin
        w_taken  = 1'b0;
        w_target = w_br_tgt;
        case (br_type)
            2'b01: begin
                w_taken  = w_accept & zero_B;
                w_target = w_br_tgt;
            end
            2'b10: begin
                w_taken  = w_accept;
                w_target = w_j_tgt;
            end
            2'b11: begin
                w_taken  = w_accept;
                w_target = w_jr_tgt;
            end
            default: begin
                w_taken  = 1'b0;
                w_target = w_br_tgt;
            end
        endcase
    end

    // Redirect FSM next-state, next PC and buffered target.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_tgt_nxt   = r_tgt_q;
        case (r_state)
            ST_RUN: begin
                if (w_advance) begin
                    if (w_taken) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_pc_nxt = r_pc + 32'd4;
                    end
                end else if (w_taken) begin
                    // Delay slot not fetched yet: park the target.
                    w_tgt_nxt   = w_target;
                    w_state_nxt = ST_PEND;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            ST_PEND: begin
                if (w_advance) begin
                    w_pc_nxt    = r_tgt_q;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_pc_nxt = r_pc;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Misalignment pulse source: an accepted jr whose rs has low bits set.
    always_comb begin
        if (w_accept && (br_type == 2'b11)) begin
            w_misalign_nxt = |jr_target[1:0];
        end else begin
            w_misalign_nxt = 1'b0;
        end
    end

    // State, PC, target buffer and misalign registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_RUN;
            r_pc       <= RESET_PC;
            r_tgt_q    <= 32'h0000_0000;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_tgt_q    <= w_tgt_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    assign pc_f             = r_pc;
    assign redirect_pending = (r_state == ST_PEND);
    assign misalign         = r_misalign;

`ifdef PC_REDIRECT_STAT_EN
    logic [15:0] r_br_total;
    logic [15:0] r_br_taken;

    // Saturating decision counters; w_accept already excludes stall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_br_total <= 16'h0000;
            r_br_taken <= 16'h0000;
        end else begin
            if (w_accept && (br_type != 2'b00) && (r_br_total != 16'hFFFF)) begin
                r_br_total <= r_br_total + 16'd1;
            end else begin
                r_br_total <= r_br_total;
            end
            if (w_taken && (r_br_taken != 16'hFFFF)) begin
                r_br_taken <= r_br_taken + 16'd1;
            end else begin
                r_br_taken <= r_br_taken;
            end
        end
    end

    assign br_total = r_br_total;
    assign br_taken = r_br_taken;
`endif

endmodule

// File: tb/tb_pc_redirect.sv
module tb_pc_redirect;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        br_valid;
    logic [1:0]  br_type;
    logic        zero_B;
    logic [31:0] id_pc;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic        fetch_ready;
    logic [31:0] pc_f;
    logic [31:0] link_addr;
    logic        redirect_pending;
    logic        misalign;
`ifdef PC_REDIRECT_STAT_EN
    logic [15:0] br_total;
    logic [15:0] br_taken;
`endif

    pc_redirect #(.RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .br_valid         (br_valid),
        .br_type          (br_type),
        .zero_B           (zero_B),
        .id_pc            (id_pc),
        .imm16            (imm16),
        .instr_index      (instr_index),
        .jr_target        (jr_target),
        .fetch_ready      (fetch_ready),
        .pc_f             (pc_f),
        .link_addr        (link_addr),
        .redirect_pending (redirect_pending),
        .misalign         (misalign)
`ifdef PC_REDIRECT_STAT_EN
        ,
        .br_total         (br_total),
        .br_taken         (br_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned edge_no;
        logic [31:0] pc;
        logic        pend;
        logic        mis;
        int          tot;
        int          tkn;
    } exp_t;

    exp_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_tgt;
    bit          m_mis;
    int          m_tot;
    int          m_tkn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = RST_PC;
        m_pend = 0;
        m_tgt  = 32'h0;
        m_mis  = 0;
        m_tot  = 0;
        m_tkn  = 0;
    endtask

    // Behavioural model of one clock edge for the given inputs.
    task automatic model_step(input bit bv, input logic [1:0] bt, input bit z,
                              input logic [31:0] idp, input logic [15:0] im,
                              input logic [25:0] ix, input logic [31:0] jt,
                              input bit fr, input bit st);
        bit          acc;
        bit          tk;
        logic [31:0] tgt;
        int          sx;
        acc = bv && !st && !m_pend;
        tk  = 0;
        tgt = 32'h0;
        sx  = $signed(im);
        if (bt == 2'd1) begin
            tk  = acc && z;
            tgt = idp + 32'd4 + 32'(sx * 4);
        end else if (bt == 2'd2) begin
            tk  = acc;
            tgt = ((idp + 32'd4) & 32'hF000_0000) | (32'(ix) * 32'd4);
        end else if (bt == 2'd3) begin
            tk  = acc;
            tgt = jt & ~32'd3;
        end
        m_mis = acc && (bt == 2'd3) && (jt[1:0] != 2'd0);
        if (acc && bt != 2'd0 && m_tot < 65535) m_tot++;
        if (tk && m_tkn < 65535) m_tkn++;
        if (!st) begin
            if (m_pend) begin
                if (fr) begin
                    m_pc   = m_tgt;
                    m_pend = 0;
                end
            end else if (fr) begin
                m_pc = tk ? tgt : m_pc + 32'd4;
            end else if (tk) begin
                m_tgt  = tgt;
                m_pend = 1;
            end
        end
    endtask

    // Apply inputs, record expectation for the coming edge, return 4 time units after it.
    task automatic drive(input bit bv, input logic [1:0] bt, input bit z,
                         input logic [31:0] idp, input logic [15:0] im,
                         input logic [25:0] ix, input logic [31:0] jt,
                         input bit fr, input bit st);
        exp_t e;
        br_valid    = bv;
        br_type     = bt;
        zero_B      = z;
        id_pc       = idp;
        imm16       = im;
        instr_index = ix;
        jr_target   = jt;
        fetch_ready = fr;
        stall       = st;
        #1;
        check("link_addr", link_addr, idp + 32'd8);
        model_step(bv, bt, z, idp, im, ix, jt, fr, st);
        e.edge_no = cyc + 1;
        e.pc      = m_pc;
        e.pend    = m_pend;
        e.mis     = m_mis;
        e.tot     = m_tot;
        e.tkn     = m_tkn;
        q.push_back(e);
        @(posedge clk);
        #4;
    endtask

    task automatic idle(input bit fr);
        drive(1'b0, 2'd0, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0, fr, 1'b0);
    endtask

    // Asynchronous reset between edges; DUT is stalled across the release.
    task automatic do_reset();
        stall    = 1'b1;
        br_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("rst_pc", pc_f, RST_PC);
        check("rst_pend", {31'h0, redirect_pending}, 32'h0);
        check("rst_mis", {31'h0, misalign}, 32'h0);
        model_reset();
        q.delete();
        #1;
        reset_n = 1'b1;
    endtask

    // Scoreboard monitor: compares DUT state after each edge that has an expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() > 0 && q[0].edge_no == cyc) begin
                e = q.pop_front();
                check("sb_pc", pc_f, e.pc);
                check("sb_pend", {31'h0, redirect_pending}, {31'h0, e.pend});
                check("sb_mis", {31'h0, misalign}, {31'h0, e.mis});
`ifdef PC_REDIRECT_STAT_EN
                check("sb_total", {16'h0, br_total}, 32'(e.tot));
                check("sb_taken", {16'h0, br_taken}, 32'(e.tkn));
`endif
            end
        end
    end

    initial begin
        int tot0;
        int tkn0;
        bit bv;
        reset_n     = 1'b0;
        stall       = 1'b1;
        br_valid    = 1'b0;
        br_type     = 2'd0;
        zero_B      = 1'b0;
        id_pc       = 32'h0;
        imm16       = 16'h0;
        instr_index = 26'h0;
        jr_target   = 32'h0;
        fetch_ready = 1'b0;
        model_reset();
        #7;
        check("init_pc", pc_f, RST_PC);
        check("init_pend", {31'h0, redirect_pending}, 32'h0);
        check("init_mis", {31'h0, misalign}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #4;

        // Reset mid-run at 0x3010
        repeat (4) idle(1'b1);
        check("run_3010", pc_f, 32'h0000_3010);
        do_reset();

        // BEQ taken
        repeat (2) idle(1'b1);
        check("pre_beq", pc_f, 32'h0000_3008);
        drive(1'b1, 2'd1, 1'b1, 32'h3004, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0);
        check("beq_taken", pc_f, 32'h0000_3014);

        // BEQ not taken
        do_reset();
        repeat (2) idle(1'b1);
        drive(1'b1, 2'd1, 1'b0, 32'h3004, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0);
        check("beq_not_taken", pc_f, 32'h0000_300C);

        // Negative offset wrap and jump region wrap
        drive(1'b1, 2'd1, 1'b1, 32'h0, 16'hFFFE, 26'h0, 32'h0, 1'b1, 1'b0);
        check("neg_wrap", pc_f, 32'hFFFF_FFFC);
        drive(1'b1, 2'd2, 1'b0, 32'h3FFF_FFFC, 16'h0, 26'h0000004, 32'h0, 1'b1, 1'b0);
        check("j_region", pc_f, 32'h4000_0010);

        // Delayed acceptance of a taken jr
        drive(1'b1, 2'd3, 1'b0, 32'h1000, 16'h0, 26'h0, 32'h3100, 1'b0, 1'b0);
        check("dly_hold0", pc_f, 32'h4000_0010);
        check("dly_pend0", {31'h0, redirect_pending}, 32'h1);
        repeat (2) idle(1'b0);
        check("dly_hold2", pc_f, 32'h4000_0010);
        check("dly_pend2", {31'h0, redirect_pending}, 32'h1);
        idle(1'b1);
        check("dly_redirect", pc_f, 32'h0000_3100);
        check("dly_clear", {31'h0, redirect_pending}, 32'h0);

        // Stall precedence
        drive(1'b1, 2'd3, 1'b0, 32'h1000, 16'h0, 26'h0, 32'h3200, 1'b1, 1'b1);
        check("stall_hold", pc_f, 32'h0000_3100);
        drive(1'b1, 2'd3, 1'b0, 32'h1000, 16'h0, 26'h0, 32'h3200, 1'b1, 1'b0);
        check("stall_release", pc_f, 32'h0000_3200);

        // Misaligned jr
        tot0 = m_tot;
        tkn0 = m_tkn;
        drive(1'b1, 2'd3, 1'b0, 32'h1000, 16'h0, 26'h0, 32'h3102, 1'b1, 1'b0);
        check("mis_pc", pc_f, 32'h0000_3100);
        check("mis_pulse", {31'h0, misalign}, 32'h1);
`ifdef PC_REDIRECT_STAT_EN
        check("mis_total", {16'h0, br_total}, 32'(tot0 + 1));
        check("mis_taken", {16'h0, br_taken}, 32'(tkn0 + 1));
`endif
        idle(1'b1);
        check("mis_drop", {31'h0, misalign}, 32'h0);

        // Reset while pending discards the target
        drive(1'b1, 2'd3, 1'b0, 32'h1000, 16'h0, 26'h0, 32'h3300, 1'b0, 1'b0);
        check("pend_before_rst", {31'h0, redirect_pending}, 32'h1);
        do_reset();
        idle(1'b1);
        check("pend_discard", pc_f, 32'h0000_3004);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end
            bv = !m_pend && ($urandom_range(0, 1) == 1);
            drive(bv, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, 16'($urandom), 26'($urandom), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0);
        end

        idle(1'b1);
        check("sb_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
